vga_line_doubler: RTL and testbench

- Scan doubler between the BBC video pixel stream and the VGA timing generator, in the same PIXELCLK domain.
- Captures each source scanline into one half of a ping-pong line buffer while the other half is read out.
- Each captured line is shown on two consecutive VGA lines, gated by the timing generator's DISEN, ENDofLINE and NEWSCREEN.

---
 rtl/vga_line_doubler.sv | 151 +++++++++++++++
 tb/tb_vga_line_doubler.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_line_doubler.sv
// ----------------------------------------------------------------------------
// vga_line_doubler
//
// Scan doubler between the BBC video pixel stream and the VGA timing
// generator. Both sides run on PIXELCLK. Each source scanline is captured
// into one half of a ping-pong line buffer while the other half is read out,
// and every captured line is shown on two consecutive VGA lines.
//
// Ports:
//   PIXELCLK     pixel clock, all logic on its rising edge
//   nRESET       synchronous, active-low reset
//   SRC_PIXEL    source pixel colour
//   SRC_WE       SRC_PIXEL valid this cycle, stored at the current write address
//   SRC_NEWLINE  single-cycle strobe, the source line ended
//   ENDofLINE    last cycle of the VGA line (from the timing generator)
//   NEWSCREEN    line before the first visible line of a frame (with ENDofLINE)
//   DISEN        visible-pixel window (from the timing generator)
//   VGA_RGB      registered pixel output
//   OVERRUN      sticky flag, a source line exceeded LINE_PIXELS
// ----------------------------------------------------------------------------
module vga_line_doubler #(
    parameter int unsigned LINE_PIXELS = 640,
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned COLOR_W     = 3
) (
    input  logic               PIXELCLK,
    input  logic               nRESET,
    input  logic [COLOR_W-1:0] SRC_PIXEL,
    input  logic               SRC_WE,
    input  logic               SRC_NEWLINE,
    input  logic               ENDofLINE,
    input  logic               NEWSCREEN,
    input  logic               DISEN,
    output logic [COLOR_W-1:0] VGA_RGB,
    output logic               OVERRUN
);

    // Counters carry one extra bit so they can hold LINE_PIXELS itself even
    // when 2^ADDR_W == LINE_PIXELS.
    localparam int unsigned    CNT_W    = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LINE_END = CNT_W'(LINE_PIXELS);

    // Two line banks; contents are never reset.
    logic [COLOR_W-1:0] mem [0:1][0:LINE_PIXELS-1];

    // Write-side state
    logic             wbank;
    logic             lastbank;
    logic [CNT_W-1:0] waddr;
    logic             wcount_nz;

    // Read-side state
    logic             rbank;
    logic             rep;
    logic [CNT_W-1:0] raddr;
    logic [CNT_W-1:0] raddr_d;
    logic             disen_d;

    // Write-side decode. A newline in the same cycle as a pixel is handled
    // first, so the pixel lands at address 0 of the (possibly swapped) bank.
    logic             swap;
    logic             cur_bank;
    logic [CNT_W-1:0] cur_addr;
    logic             do_write;
    logic             do_overrun;

    always_comb begin
        swap       = SRC_NEWLINE & wcount_nz;
        cur_bank   = swap ? ~wbank : wbank;
        cur_addr   = SRC_NEWLINE ? '0 : waddr;
        do_write   = SRC_WE & (cur_addr < LINE_END);
        do_overrun = SRC_WE & ~do_write;
    end

    // Read-side decode. NEWSCREEN forces the pair phase back to the first
    // line of a pair; a bank is latched only when entering the first line.
    logic rep_next;
    logic rd_valid;

    always_comb begin
        rep_next = NEWSCREEN ? 1'b0 : ~rep;
        rd_valid = disen_d & (raddr_d < LINE_END);
    end

    // Line-buffer write port. Writes are suppressed while in reset so an
    // abandoned line cannot disturb the buffer during the reset cycle.
    always_ff @(posedge PIXELCLK) begin
        if (nRESET && do_write) begin
            mem[cur_bank][cur_addr[ADDR_W-1:0]] <= SRC_PIXEL;
        end
    end

    // Write-side control
    always_ff @(posedge PIXELCLK) begin
        if (!nRESET) begin
            wbank     <= 1'b0;
            lastbank  <= 1'b0;
            waddr     <= '0;
            wcount_nz <= 1'b0;
            OVERRUN   <= 1'b0;
        end else begin
            if (swap) begin
                lastbank <= wbank;
                wbank    <= ~wbank;
            end
            // Holds at LINE_PIXELS on overrun, restarts at 0 on newline.
            waddr     <= do_write ? cur_addr + CNT_W'(1) : cur_addr;
            wcount_nz <= do_write | (wcount_nz & ~SRC_NEWLINE);
            if (do_overrun) begin
                OVERRUN <= 1'b1;
            end
        end
    end

    // Read-side control. rbank is loaded from the registered lastbank, so a
    // simultaneous source newline never redirects the latch to the bank that
    // is still being written.
    always_ff @(posedge PIXELCLK) begin
        if (!nRESET) begin
            rbank   <= 1'b0;
            rep     <= 1'b0;
            raddr   <= '0;
            raddr_d <= '0;
            disen_d <= 1'b0;
        end else begin
            if (ENDofLINE) begin
                rep   <= rep_next;
                raddr <= '0;
                if (!rep_next) begin
                    rbank <= lastbank;
                end
            end else if (DISEN && (raddr < LINE_END)) begin
                raddr <= raddr + CNT_W'(1);
            end
            raddr_d <= raddr;
            disen_d <= DISEN;
        end
    end

    // Output register doubles as the synchronous read stage of the buffer.
    always_ff @(posedge PIXELCLK) begin
        if (!nRESET) begin
            VGA_RGB <= '0;
        end else if (rd_valid) begin
            VGA_RGB <= mem[rbank][raddr_d[ADDR_W-1:0]];
        end else begin
            VGA_RGB <= '0;
        end
    end

endmodule

// File: tb/tb_vga_line_doubler.sv
// ----------------------------------------------------------------------------
// tb_vga_line_doubler
//
// Drives the source and VGA timing inputs one cycle at a time. Each cycle
// pushes the expected VGA_RGB for that cycle's inputs into a scoreboard queue;
// the value is popped and compared once the two-edge output latency elapses.
// The expected line content for each VGA line is chosen by the test sequence.
// ----------------------------------------------------------------------------
module tb_vga_line_doubler;

    localparam int unsigned NPIX = 640;

    logic       clk;
    logic       n_reset;
    logic [2:0] src_pixel;
    logic       src_we;
    logic       src_newline;
    logic       end_of_line;
    logic       new_screen;
    logic       disen;
    logic [2:0] vga_rgb;
    logic       overrun;

    vga_line_doubler #(
        .LINE_PIXELS (640),
        .ADDR_W      (10),
        .COLOR_W     (3)
    ) dut (
        .PIXELCLK    (clk),
        .nRESET      (n_reset),
        .SRC_PIXEL   (src_pixel),
        .SRC_WE      (src_we),
        .SRC_NEWLINE (src_newline),
        .ENDofLINE   (end_of_line),
        .NEWSCREEN   (new_screen),
        .DISEN       (disen),
        .VGA_RGB     (vga_rgb),
        .OVERRUN     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [2:0] exp_q [$];
    logic [2:0] show [NPIX];
    int         vpos = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Pixel patterns used by the different source lines.
    function automatic logic [2:0] pat(input int k, input int i);
        int v;
        case (k)
            0:       v = 5;
            1:       v = i % 8;
            2:       v = 7 - (i % 8);
            3:       v = (3 * i + 1) % 8;
            4:       v = (i == 0) ? 7 : (i % 5) + 1;
            5:       v = (i / 8) % 8;
            default: v = (5 * i + 2) % 8;
        endcase
        return 3'(v);
    endfunction

    task automatic set_show(input int k);
        for (int i = 0; i < NPIX; i++) show[i] = pat(k, i);
    endtask

    // One clock cycle: check the output due now, drive new inputs, push the
    // expected output for those inputs.
    task automatic tick(input logic rst_n, input logic de, input logic eol, input logic ns,
                        input logic we, input logic nl, input logic [2:0] pix);
        logic [2:0] want;
        @(negedge clk);
        if (exp_q.size() >= 2) begin
            want = exp_q.pop_front();
            check_eq("rgb", {29'd0, vga_rgb}, {29'd0, want});
        end
        n_reset     = rst_n;
        disen       = de;
        end_of_line = eol;
        new_screen  = ns;
        src_we      = we;
        src_newline = nl;
        src_pixel   = pix;
        if (!rst_n) begin
            // Reset clears the output register and the read pointer.
            foreach (exp_q[i]) exp_q[i] = 3'd0;
            want = 3'd0;
            vpos = 0;
        end else begin
            want = (de && vpos < NPIX) ? show[vpos] : 3'd0;
            if (eol) vpos = 0;
            else if (de && vpos < NPIX) vpos++;
        end
        exp_q.push_back(want);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1, 0, 0, 0, 0, 0, 3'd0);
    endtask

    // Write n source pixels of pattern k starting at index start, with the
    // VGA side idle; optionally end the line with SRC_NEWLINE.
    task automatic src_write(input int k, input int start, input int n, input bit nl);
        for (int i = start; i < start + n; i++) tick(1, 0, 0, 0, 1, 0, pat(k, i));
        if (nl) tick(1, 0, 0, 0, 0, 1, 3'd0);
    endtask

    // One VGA line: ENDofLINE (+NEWSCREEN) cycle, 2 blank, dn visible, rest
    // blank, len cycles total. sync_nl puts SRC_NEWLINE+SRC_WE(7) on the
    // ENDofLINE cycle. wk >= 0 writes wn pixels of pattern wk alongside.
    task automatic vga_line(input bit ns, input bit sync_nl, input int wk, input int wn,
                            input int dn, input int len);
        int w = 0;
        for (int c = 0; c < len; c++) begin
            logic de;
            logic we;
            de = (c >= 3) && (c < 3 + dn);
            if (c == 0) begin
                tick(1, de, 1, ns, sync_nl, sync_nl, sync_nl ? 3'd7 : 3'd0);
            end else begin
                we = (wk >= 0) && (w < wn);
                tick(1, de, 0, 0, we, 0, we ? pat(wk, w) : 3'd0);
                if (we) w++;
            end
        end
    endtask

    initial begin
        n_reset     = 1'b0;
        src_pixel   = '0;
        src_we      = 1'b0;
        src_newline = 1'b0;
        end_of_line = 1'b0;
        new_screen  = 1'b0;
        disen       = 1'b0;
        for (int i = 0; i < NPIX; i++) show[i] = 3'd0;

        repeat (3) tick(0, 0, 0, 0, 0, 0, 3'd0);
        idle(2);
        check_eq("ovr_reset", {31'd0, overrun}, 32'd0);

        // Constant line shown twice.
        src_write(0, 0, NPIX, 1);
        set_show(0);
        vga_line(1, 0, -1, 0, NPIX, 646);
        vga_line(0, 0, -1, 0, NPIX, 646);
        check_eq("ovr_clean", {31'd0, overrun}, 32'd0);

        // Ramp A, then B written while A is displayed.
        src_write(1, 0, NPIX, 1);
        set_show(1);
        vga_line(0, 0, 2, NPIX, NPIX, 646);
        tick(1, 0, 0, 0, 0, 1, 3'd0);
        vga_line(0, 0, -1, 0, NPIX, 646);
        set_show(2);
        vga_line(0, 0, -1, 0, NPIX, 646);
        vga_line(0, 0, -1, 0, NPIX, 646);

        // Overrun: 645 pixels, only 640 stored.
        src_write(3, 0, 645, 1);
        idle(1);
        check_eq("ovr_set", {31'd0, overrun}, 32'd1);
        set_show(3);
        vga_line(0, 0, -1, 0, NPIX, 646);
        vga_line(0, 0, -1, 0, NPIX, 646);
        check_eq("ovr_sticky", {31'd0, overrun}, 32'd1);

        // Empty newline: previous line repeated on the next pair.
        tick(1, 0, 0, 0, 0, 1, 3'd0);
        vga_line(0, 0, -1, 0, NPIX, 646);
        vga_line(0, 0, -1, 0, NPIX, 646);

        // Newline + pixel coincident with the latch: old lastbank (pattern 3)
        // is shown; its pixel 0 was just overwritten by the new line's 7.
        src_write(5, 0, NPIX, 0);
        set_show(3);
        show[0] = 3'd7;
        vga_line(0, 1, -1, 0, NPIX, 646);
        vga_line(0, 0, -1, 0, NPIX, 646);
        src_write(4, 1, NPIX - 1, 1);
        set_show(4);
        vga_line(0, 0, -1, 0, NPIX, 646);
        vga_line(0, 0, -1, 0, NPIX, 646);
        check_eq("ovr_hold", {31'd0, overrun}, 32'd1);

        // Reset mid-line with a partial source line in flight.
        vga_line(0, 0, 0, 100, NPIX, 103);
        tick(0, 0, 0, 0, 0, 0, 3'd0);
        idle(1);
        check_eq("ovr_cleared", {31'd0, overrun}, 32'd0);
        idle(4);
        src_write(6, 0, NPIX, 1);
        set_show(6);
        vga_line(1, 0, -1, 0, NPIX, 646);
        vga_line(0, 0, -1, 0, NPIX, 646);
        idle(4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
